// File: rtl/hdmi_pkg.sv
// Shared encodings for the HDMI period scheduler: period modes, preamble CTL
// patterns, guard-band codes and the fixed period lengths.
package hdmi_pkg;

  typedef enum logic [2:0] {
    M_CTRL      = 3'd0,
    M_VID_PRE   = 3'd1,
    M_VID_GUARD = 3'd2,
    M_VIDEO     = 3'd3,
    M_ISL_PRE   = 3'd4,
    M_ISL_GUARD = 3'd5,
    M_ISL_DATA  = 3'd6
  } mode_e;

  typedef struct packed {
    logic        de;
    logic        vs;
    logic        hs;
    logic [23:0] d;
  } vid_word_t;

  localparam int CNT_W = 7;

  // Pixel-path latency; the delay line holds all but the output register.
  localparam int VID_DELAY = 12;

  localparam int VID_PRE_LEN   = 8;
  localparam int VID_GUARD_LEN = 2;
  localparam int ISL_PRE_LEN   = 8;
  localparam int ISL_GUARD_LEN = 2;

  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] CTL_ISL_PRE = 4'b0101;
  localparam logic [3:0] CTL_IDLE    = 4'b0000;

  // TMDS 10-bit guard-band characters used by the downstream encoders.
  localparam logic [9:0] VID_GB_CH0 = 10'b1011001100;
  localparam logic [9:0] VID_GB_CH1 = 10'b0100110011;
  localparam logic [9:0] VID_GB_CH2 = 10'b1011001100;
  localparam logic [9:0] ISL_GB_CH1 = 10'b0100110011;
  localparam logic [9:0] ISL_GB_CH2 = 10'b0100110011;

  function automatic logic [3:0] ctl_for_mode(input mode_e m);
    case (m)
      M_VID_PRE: return CTL_VID_PRE;
      M_ISL_PRE: return CTL_ISL_PRE;
      default:   return CTL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_video_delay.sv
// Fixed-depth shift register that aligns the pixel/sync stream with the
// scheduler's look-ahead; reset flushes it so stale DE cannot leak out.
module hdmi_video_delay #(
  parameter int DEPTH = 11,
  parameter int W     = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [DEPTH-1:0][W-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Chooses the HDMI period type for every output cycle: video preambles/guards
// ahead of delayed video, and one data island per video-to-blank transition.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int CTL_GAP     = 12,
  parameter int ISL_PKT_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DE,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] D,
  input  logic        island_req,
  input  logic [11:0] island_data,
  output logic        island_ack,
  output logic        island_rd,
  output mode_e       mode,
  output logic [3:0]  ctl,
  output logic [1:0]  sync,
  output logic [23:0] q_d,
  output logic [11:0] q_nib,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] GAP      = CNT_W'(CTL_GAP);
  localparam logic [CNT_W-1:0] VPRE     = CNT_W'(VID_PRE_LEN);
  localparam logic [CNT_W-1:0] VLAST    = CNT_W'(VID_PRE_LEN + VID_GUARD_LEN - 1);
  localparam logic [CNT_W-1:0] IPRE     = CNT_W'(ISL_PRE_LEN);
  localparam logic [CNT_W-1:0] IGB      = CNT_W'(ISL_PRE_LEN + ISL_GUARD_LEN);
  localparam logic [CNT_W-1:0] IDAT_END = CNT_W'(ISL_PRE_LEN + ISL_GUARD_LEN + ISL_PKT_LEN);
  localparam logic [CNT_W-1:0] IEND     = CNT_W'(ISL_PRE_LEN + 2*ISL_GUARD_LEN + ISL_PKT_LEN);

  vid_word_t vid_in, dly;

  assign vid_in = '{de: DE, vs: vsync, hs: hsync, d: D};

  hdmi_video_delay #(
    .DEPTH (VID_DELAY - 1),
    .W     ($bits(vid_word_t))
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .din_i  (vid_in),
    .dout_o (dly)
  );

  // Two-deep DE history: a rise seen here is 10 cycles ahead of the output.
  logic de_s1_q, de_s2_q;
  logic vid_rise;

  assign vid_rise = de_s1_q & ~de_s2_q;

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] vpos_q, vpos_d;
  logic [CNT_W-1:0] ipos_q, ipos_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic             ack_q, ack_d;
  logic             rd_q, rd_d;
  logic             ovr_q, ovr_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [1:0]       sync_q, sync_d;
  logic [23:0]      pix_q, pix_d;
  logic [11:0]      nib_q, nib_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      de_s1_q <= 1'b0;
      de_s2_q <= 1'b0;
      mode_q  <= M_CTRL;
      vpos_q  <= '0;
      ipos_q  <= '0;
      gcnt_q  <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      ovr_q   <= 1'b0;
      ctl_q   <= '0;
      sync_q  <= '0;
      pix_q   <= '0;
      nib_q   <= '0;
    end else begin
      de_s1_q <= DE;
      de_s2_q <= de_s1_q;
      mode_q  <= mode_d;
      vpos_q  <= vpos_d;
      ipos_q  <= ipos_d;
      gcnt_q  <= gcnt_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      ovr_q   <= ovr_d;
      ctl_q   <= ctl_d;
      sync_q  <= sync_d;
      pix_q   <= pix_d;
      nib_q   <= nib_d;
    end
  end

  // vpos/ipos/gcnt are 0 when idle; otherwise they index the current window.
  always_comb begin
    mode_d = M_CTRL;
    vpos_d = '0;
    ipos_d = '0;
    gcnt_d = '0;
    ack_d  = 1'b0;
    rd_d   = 1'b0;
    ovr_d  = 1'b0;
    if (vid_rise) begin
      mode_d = M_VID_PRE;
      vpos_d = CNT_W'(1);
      ovr_d  = (ipos_q != '0);
    end else if (vpos_q != '0) begin
      mode_d = (vpos_q < VPRE) ? M_VID_PRE : M_VID_GUARD;
      vpos_d = (vpos_q == VLAST) ? '0 : vpos_q + CNT_W'(1);
    end else if (dly.de) begin
      mode_d = M_VIDEO;
    end else if (ipos_q != '0) begin
      ipos_d = ipos_q + CNT_W'(1);
      if (ipos_q < IPRE)          mode_d = M_ISL_PRE;
      else if (ipos_q < IGB)      mode_d = M_ISL_GUARD;
      else if (ipos_q < IDAT_END) mode_d = M_ISL_DATA;
      else if (ipos_q < IEND)     mode_d = M_ISL_GUARD;
      else begin
        mode_d = M_CTRL;
        ipos_d = '0;
      end
      // Strobe leads each data output cycle by one.
      rd_d = (ipos_q >= IGB - CNT_W'(1)) && (ipos_q < IDAT_END - CNT_W'(1));
    end else if (gcnt_q != '0) begin
      // Decision cycle is one-shot: a late request waits for the next blank.
      if (gcnt_q == GAP) begin
        if (island_req) begin
          mode_d = M_ISL_PRE;
          ipos_d = CNT_W'(1);
          ack_d  = 1'b1;
        end
      end else begin
        gcnt_d = (gcnt_q > GAP) ? GAP : gcnt_q + CNT_W'(1);
      end
    end else if (mode_q == M_VIDEO) begin
      gcnt_d = CNT_W'(1);
    end
  end

  always_comb begin
    ctl_d  = ctl_for_mode(mode_d);
    sync_d = {dly.vs, dly.hs};
    pix_d  = dly.d;
    nib_d  = '0;
    if (mode_d == M_ISL_DATA) begin
      nib_d      = island_data;
      nib_d[1:0] = {dly.vs, dly.hs};
    end
  end

  assign mode       = mode_q;
  assign ctl        = ctl_q;
  assign sync       = sync_q;
  assign q_d        = pix_q;
  assign q_nib      = nib_q;
  assign island_ack = ack_q;
  assign island_rd  = rd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench: one long timeline (video, island, overrun, cancelled island,
// reset mid-video) checked against a table of hand-computed expectations.
module tb_hdmi_period_scheduler;
  import hdmi_pkg::*;

  logic        clk = 1'b0;
  logic        reset, DE, hsync, vsync, island_req;
  logic [23:0] D;
  logic [11:0] island_data;
  logic        island_ack, island_rd, overrun;
  mode_e       mode;
  logic [3:0]  ctl;
  logic [1:0]  sync;
  logic [23:0] q_d;
  logic [11:0] q_nib;

  hdmi_period_scheduler #(.CTL_GAP(12), .ISL_PKT_LEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .DE          (DE),
    .hsync       (hsync),
    .vsync       (vsync),
    .D           (D),
    .island_req  (island_req),
    .island_data (island_data),
    .island_ack  (island_ack),
    .island_rd   (island_rd),
    .mode        (mode),
    .ctl         (ctl),
    .sync        (sync),
    .q_d         (q_d),
    .q_nib       (q_nib),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    mode_e       mode;
    logic [3:0]  ctl;
    logic        ack;
    logic        rd;
    logic        ovr;
    logic [1:0]  sync;
    logic [11:0] nib;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic add(input int c, input mode_e m, input logic [3:0] ct, input logic a,
                     input logic r, input logic o, input logic [1:0] s, input logic [11:0] n);
    vec_t v;
    v.cyc = c; v.mode = m; v.ctl = ct; v.ack = a; v.rd = r; v.ovr = o; v.sync = s; v.nib = n;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, c, got, exp);
    end
  endtask

  // Input waveform for input cycle c.
  task automatic drive(input int c);
    reset       = (c < 5) || (c == 1050);
    DE          = (c >= 100 && c < 500) || (c >= 700 && c < 800) ||
                  (c >= 840 && c < 900) || (c >= 1000 && c < 1100);
    hsync       = (c >= 505 && c < 510);
    vsync       = (c >= 510 && c < 560);
    D           = 24'hC00000 | 24'(c);
    island_req  = (c >= 200 && c < 915) || (c >= 926);
    island_data = 12'hABC;
  endtask

  initial begin
    int ri;
    // reset state
    add(3,    M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    // video start
    add(101,  M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(102,  M_VID_PRE,   4'h1, 0, 0, 0, 2'b00, 12'h000);
    add(109,  M_VID_PRE,   4'h1, 0, 0, 0, 2'b00, 12'h000);
    add(110,  M_VID_GUARD, 4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(111,  M_VID_GUARD, 4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(112,  M_VIDEO,     4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(511,  M_VIDEO,     4'h0, 0, 0, 0, 2'b00, 12'h000);
    // control gap then island
    add(512,  M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(517,  M_CTRL,      4'h0, 0, 0, 0, 2'b01, 12'h000);
    add(523,  M_CTRL,      4'h0, 0, 0, 0, 2'b10, 12'h000);
    add(524,  M_ISL_PRE,   4'h5, 1, 0, 0, 2'b10, 12'h000);
    add(525,  M_ISL_PRE,   4'h5, 0, 0, 0, 2'b10, 12'h000);
    add(531,  M_ISL_PRE,   4'h5, 0, 0, 0, 2'b10, 12'h000);
    add(532,  M_ISL_GUARD, 4'h0, 0, 0, 0, 2'b10, 12'h000);
    add(533,  M_ISL_GUARD, 4'h0, 0, 1, 0, 2'b10, 12'h000);
    add(534,  M_ISL_DATA,  4'h0, 0, 1, 0, 2'b10, 12'hABE);
    add(564,  M_ISL_DATA,  4'h0, 0, 1, 0, 2'b10, 12'hABE);
    add(565,  M_ISL_DATA,  4'h0, 0, 0, 0, 2'b10, 12'hABE);
    add(566,  M_ISL_GUARD, 4'h0, 0, 0, 0, 2'b10, 12'h000);
    add(567,  M_ISL_GUARD, 4'h0, 0, 0, 0, 2'b10, 12'h000);
    add(568,  M_CTRL,      4'h0, 0, 0, 0, 2'b10, 12'h000);
    // second island aborted by early video
    add(824,  M_ISL_PRE,   4'h5, 1, 0, 0, 2'b00, 12'h000);
    add(841,  M_ISL_DATA,  4'h0, 0, 1, 0, 2'b00, 12'hABC);
    add(842,  M_VID_PRE,   4'h1, 0, 0, 1, 2'b00, 12'h000);
    add(843,  M_VID_PRE,   4'h1, 0, 0, 0, 2'b00, 12'h000);
    add(850,  M_VID_GUARD, 4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(852,  M_VIDEO,     4'h0, 0, 0, 0, 2'b00, 12'h000);
    // request withdrawn before decision, returns too late
    add(923,  M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(924,  M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(940,  M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    // reset pulse mid-video
    add(1049, M_VIDEO,     4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(1051, M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(1052, M_CTRL,      4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(1053, M_VID_PRE,   4'h1, 0, 0, 0, 2'b00, 12'h000);
    add(1062, M_VID_GUARD, 4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(1063, M_VIDEO,     4'h0, 0, 0, 0, 2'b00, 12'h000);
    add(1124, M_ISL_PRE,   4'h5, 1, 0, 0, 2'b00, 12'h000);

    ri = 0;
    drive(0);
    for (int c = 1; c < 1200; c++) begin
      @(posedge clk);
      #1;
      if (ri < tbl.size() && tbl[ri].cyc == c) begin
        chk("mode", c, 32'(mode),       32'(tbl[ri].mode));
        chk("ctl",  c, 32'(ctl),        32'(tbl[ri].ctl));
        chk("ack",  c, 32'(island_ack), 32'(tbl[ri].ack));
        chk("rd",   c, 32'(island_rd),  32'(tbl[ri].rd));
        chk("ovr",  c, 32'(overrun),    32'(tbl[ri].ovr));
        chk("sync", c, 32'(sync),       32'(tbl[ri].sync));
        chk("nib",  c, 32'(q_nib),      32'(tbl[ri].nib));
        ri++;
      end
      if (c == 3)    chk("q_d_reset", c, 32'(q_d), 32'h000000);
      if (c == 112)  chk("q_d_vid",   c, 32'(q_d), 32'hC00064);
      if (c == 200)  chk("q_d_vid2",  c, 32'(q_d), 32'hC000BC);
      if (c == 1051) chk("q_d_rst",   c, 32'(q_d), 32'h000000);
      if (c == 1062) chk("q_d_flush", c, 32'(q_d), 32'h000000);
      if (c == 1063) chk("q_d_resume",c, 32'(q_d), 32'hC0041B);
      drive(c);
    end
    chk("table_consumed", 0, 32'(ri), 32'(tbl.size()));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 SHALL have parameter CTL_GAP, default 12: control cycles after video ends before an island preamble.
REQ-002 SHALL have parameter ISL_PKT_LEN, default 32: island data cycles per packet.
REQ-003 SHALL have port clk, input, 1 bit: single clock, pixel rate.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port DE, input, 1 bit: active video from the timing generator.
REQ-006 SHALL have ports hsync and vsync, input, 1 bit each: syncs from the timing generator.
REQ-007 SHALL have port D, input, 24 bits: pixel {ch2, ch1, ch0}.
REQ-008 SHALL have port island_req, input, 1 bit: level request that one packet is pending.
REQ-009 SHALL have port island_data, input, 12 bits: TERC4 nibbles {ch2, ch1, ch0}, sampled when island_rd=1.
REQ-010 SHALL have port island_ack, output, 1 bit: one-cycle pulse on the first ISL_PRE output cycle.
REQ-011 SHALL have port island_rd, output, 1 bit: data strobe, high on the cycle before each ISL_DATA output cycle.
REQ-012 SHALL have port mode, output, 3 bits: period type per cycle, shared by all three encoders.
REQ-013 SHALL have port ctl, output, 4 bits: CTL3..CTL0 (CTL0/1 to ch1, CTL2/3 to ch2).
REQ-014 SHALL have port sync, output, 2 bits: {vsync, hsync} for ch0.
REQ-015 SHALL have ports q_d (24 bits) and q_nib (12 bits), output: pixel and island nibbles.
REQ-016 SHALL have port overrun, output, 1 bit: one-cycle pulse when an island is aborted.

Function
REQ-017 SHALL support modes CTRL, VID_PRE, VID_GUARD, VIDEO, ISL_PRE, ISL_GUARD and ISL_DATA.
REQ-018 SHALL delay DE, hsync, vsync and D by 12 cycles (input cycle n appears on the outputs at cycle n+12).
REQ-019 On a DE rise at input cycle t, SHALL output VID_PRE for cycles t+2..t+9, VID_GUARD for t+10..t+11 and VIDEO from t+12 for as long as the delayed DE is 1.
REQ-020 SHALL drive ctl=4'b0001 during VID_PRE, ctl=4'b0101 during ISL_PRE and ctl=0 otherwise.
REQ-021 After an output VIDEO-to-CTRL transition, SHALL count control cycles; when the count reaches CTL_GAP and island_req=1, SHALL start an island.
REQ-022 An island SHALL consist of ISL_PRE for 8 cycles, ISL_GUARD for 2, ISL_DATA for ISL_PKT_LEN cycles, ISL_GUARD for 2, then CTRL.
REQ-023 SHALL start at most one island per video-to-blank transition; no island during vertical blanking.
REQ-024 During ISL_DATA, q_nib SHALL equal the island_data sampled the previous cycle; bits [1:0] of ch0 SHALL be replaced by {vsync, hsync}.
REQ-025 sync SHALL always carry the delayed {vsync, hsync}, including during preambles and guards.
REQ-026 If a VID_PRE must start while an island is active, video SHALL win: mode switches to VID_PRE that cycle, island_rd drops and overrun pulses.
REQ-027 island_req deasserted before the decision cycle SHALL cancel the island with no ack.
REQ-028 All outputs SHALL be registered; the counters SHALL be 7 bits, saturating at CTL_GAP.

Reset
REQ-029 Reset SHALL clear the delay line (DE=0), set mode=CTRL, ctl=0, sync=0, q_d=0, q_nib=0, island_ack=0, island_rd=0 and overrun=0.
REQ-030 Reset mid-island SHALL abandon the packet without an ack or overrun pulse; the first valid output SHALL follow 12 cycles after reset release.

Structure
REQ-031 Package hdmi_pkg SHALL hold the mode encoding, the preamble CTL constants and the video and island guard-band codes.
REQ-032 The delay line SHALL be the sub-module hdmi_video_delay (parameterised depth and width).

Verification
REQ-033 DE rises at t=100 -> mode=VID_PRE at 102..109, VID_GUARD at 110..111, VIDEO at 112 with q_d equal to D from t=100.
REQ-034 island_req=1, DE falls at t=500 -> CTRL at 512..523, ISL_PRE at 524..531 with island_ack at 524, ISL_DATA at 534..565, trailing guard at 566..567, then CTRL.
REQ-035 island_data=12'hABC during data with vsync=1, hsync=0 -> q_nib=12'hABE.
REQ-036 DE rises early so that VID_PRE starts mid-ISL_DATA -> overrun=1 for one cycle, VID_PRE begins that cycle, island_rd=0.
REQ-037 reset pulse mid-VIDEO -> next cycle mode=CTRL, ctl=0, all outputs 0.
REQ-038 island_req dropped before the decision cycle -> no ISL_PRE and no island_ack.
